// File: rtl/ahb_ram_slave.sv
// rtl/ahb_ram_slave.sv - AHB-Lite word-organised data RAM slave with programmable wait states and two-cycle ERROR.
// Optional build macro RAM_MISALIGN_ERR_EN turns misaligned half/word accesses into ERROR responses.
module ahb_ram_slave #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsel,
    input  logic        hready_in,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [3:0]  hprot,
    input  logic [31:0] hwdata,
    input  logic        is_signed,
    output logic [31:0] hrdata_data,
    output logic        hready_data,
    output logic        hresp_data
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam bit HAS_WAIT = (WAIT_STATES > 0);
    localparam logic [3:0] WS_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    state_t state, state_n;
    logic [3:0] cnt, cnt_n;

    // Captured address-phase attributes of the transfer currently in its data phase.
    logic          pend;
    logic [AW-1:0] cap_idx;
    logic          cap_write;
    logic [1:0]    cap_size;
    logic          cap_signed;
    logic [1:0]    cap_off;
    logic [3:0]    cap_be;

    logic [31:0] mem [DEPTH_WORDS];

    logic       accept;
    logic       bad_size;
    logic       out_of_range;
    logic       misalign;
    logic       illegal;
    logic [1:0] req_off;
    logic [3:0] req_be;
    logic       wr_commit;
    logic       rd_valid;
    logic [31:0] rd_word;
    logic [31:0] rd_shift;

    logic unused_inputs;
    assign unused_inputs = ^{hprot, htrans[0]};

    assign accept       = hsel & htrans[1] & hready_in;
    assign bad_size     = (hsize > 3'd2);
    assign out_of_range = |haddr[31:AW+2];

`ifdef RAM_MISALIGN_ERR_EN
    assign misalign = ((hsize == 3'b001) && haddr[0]) ||
                      ((hsize == 3'b010) && (haddr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign illegal = bad_size | out_of_range | misalign;

    // Low address bits are forced to the natural alignment of the access size.
    always_comb begin
        req_off = 2'b00;
        req_be  = 4'b1111;
        case (hsize)
            3'b000: begin
                req_off = haddr[1:0];
                req_be  = 4'b0001 << haddr[1:0];
            end
            3'b001: begin
                req_off = {haddr[1], 1'b0};
                req_be  = haddr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                req_off = 2'b00;
                req_be  = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        hready_data = 1'b1;
        hresp_data  = 1'b0;
        case (state)
            ST_IDLE, ST_ERR2: begin
                hready_data = 1'b1;
                hresp_data  = (state == ST_ERR2);
                state_n     = ST_IDLE;
                if (accept) begin
                    if (illegal) begin
                        state_n = ST_ERR1;
                    end else if (HAS_WAIT) begin
                        state_n = ST_WAIT;
                        cnt_n   = WS_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                hready_data = 1'b0;
                if (cnt == 4'd0) begin
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            ST_ERR1: begin
                hready_data = 1'b0;
                hresp_data  = 1'b1;
                state_n     = ST_ERR2;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Attributes are sampled only when the previous data phase is completing.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend       <= 1'b0;
            cap_idx    <= '0;
            cap_write  <= 1'b0;
            cap_size   <= 2'b00;
            cap_signed <= 1'b0;
            cap_off    <= 2'b00;
            cap_be     <= 4'b0000;
        end else if (hready_data) begin
            pend <= accept & ~illegal;
            if (accept & ~illegal) begin
                cap_idx    <= haddr[AW+1:2];
                cap_write  <= hwrite;
                cap_size   <= hsize[1:0];
                cap_signed <= is_signed;
                cap_off    <= req_off;
                cap_be     <= req_be;
            end
        end
    end

    assign wr_commit = pend & cap_write & (state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst && wr_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (cap_be[i]) begin
                    mem[cap_idx][8*i +: 8] <= hwdata[8*i +: 8];
                end
            end
        end
    end

    // Asynchronous read of the captured word so a write committed on the previous edge is visible.
    assign rd_word  = mem[cap_idx];
    assign rd_shift = rd_word >> {cap_off, 3'b000};
    assign rd_valid = pend & ~cap_write & hready_data & ~hresp_data;

    always_comb begin
        hrdata_data = 32'd0;
        if (rd_valid) begin
            case (cap_size)
                2'b00:   hrdata_data = {{24{cap_signed & rd_shift[7]}}, rd_shift[7:0]};
                2'b01:   hrdata_data = {{16{cap_signed & rd_shift[15]}}, rd_shift[15:0]};
                default: hrdata_data = rd_word;
            endcase
        end
    end

endmodule
